// File: rtl/sqrt_iter_param_if.sv
// sqrt_iter_param_if: start/done handshake and result bus for sqrt_iter_param (result_rnd present with SQRT_ROUND_EN)
interface sqrt_iter_param_if #(parameter int WIDTH = 16);
  logic start;
  logic [WIDTH-1:0] a;
  logic busy;
  logic done;
  logic [WIDTH/2-1:0] result;
  logic [WIDTH/2:0] rem;
`ifdef SQRT_ROUND_EN
  logic [WIDTH/2:0] result_rnd;
  modport master (output start, a, input busy, done, result, rem, result_rnd);
  modport slave (input start, a, output busy, done, result, rem, result_rnd);
`else
  modport master (output start, a, input busy, done, result, rem);
  modport slave (input start, a, output busy, done, result, rem);
`endif
endinterface

// File: rtl/sqrt_iter_param.sv
// sqrt_iter_param: one-bit-per-clock restoring integer sqrt with remainder (SQRT_ROUND_EN adds result_rnd)
module sqrt_iter_param #(
  parameter int WIDTH = 16
) (
  input logic clk,
  input logic reset,
  sqrt_iter_param_if.slave s
);
  localparam int N = WIDTH / 2;
  localparam int CW = $clog2(N);
  if (WIDTH % 2 != 0 || WIDTH < 4) begin : g_bad_width
    $error("sqrt_iter_param: WIDTH must be even and >= 4");
  end
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] opr;
  logic [N-1:0] proot, proot_n;
  logic [N+1:0] prem, prem_n, rs, trial;
  logic [CW-1:0] cnt;
  logic accept, ge;
  // prem < 2^N before the shift, so dropping its top two bits loses nothing
  always_comb begin
    accept = state != CALC && s.start;
    nxt = state == CALC ? (cnt == '0 ? DONE : CALC) : (s.start ? CALC : IDLE);
    rs = {prem[N-1:0], opr[WIDTH-1 -: 2]};
    trial = {proot, 2'b01};
    ge = rs >= trial;
    prem_n = ge ? rs - trial : rs;
    proot_n = {proot[N-2:0], ge};
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opr <= '0;
      proot <= '0;
      prem <= '0;
      cnt <= '0;
      s.result <= '0;
      s.rem <= '0;
`ifdef SQRT_ROUND_EN
      s.result_rnd <= '0;
`endif
    end else if (accept) begin
      opr <= s.a;
      proot <= '0;
      prem <= '0;
      cnt <= CW'(N - 1);
    end else if (state == CALC) begin
      opr <= {opr[WIDTH-3:0], 2'b00};
      proot <= proot_n;
      prem <= prem_n;
      cnt <= cnt - CW'(1);
      if (cnt == '0) begin
        s.result <= proot_n;
        s.rem <= prem_n[N:0];
`ifdef SQRT_ROUND_EN
        s.result_rnd <= {1'b0, proot_n} + (N+1)'(prem_n > {2'b00, proot_n});
`endif
      end
    end
  end
  assign s.busy = state == CALC;
  assign s.done = state == DONE;
endmodule

// File: tb/tb_sqrt_iter_param.sv
// tb_sqrt_iter_param: directed checks of sqrt_iter_param at WIDTH 16, 8 and 32
module tb_sqrt_iter_param;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int cmp = 0;
  int errs = 0;
  sqrt_iter_param_if #(.WIDTH(16)) i16 ();
  sqrt_iter_param_if #(.WIDTH(8)) i8 ();
  sqrt_iter_param_if #(.WIDTH(32)) i32 ();
  sqrt_iter_param #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .s(i16));
  sqrt_iter_param #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .s(i8));
  sqrt_iter_param #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .s(i32));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic wait_done(output int n, output int b);
    n = 0;
    b = 0;
    while (!i16.done && n < 20) begin
      b += int'(i16.busy);
      @(negedge clk);
      n++;
    end
  endtask
  task automatic run16(input string tag, input logic [15:0] av, input int er, input int erem, input int ernd);
    int n, b;
    i16.a = av;
    i16.start = 1'b1;
    @(negedge clk);
    i16.start = 1'b0;
    wait_done(n, b);
    chk({tag, "_lat"}, n, 8);
    chk({tag, "_res"}, i16.result, er);
    chk({tag, "_rem"}, i16.rem, erem);
`ifdef SQRT_ROUND_EN
    chk({tag, "_rnd"}, i16.result_rnd, ernd);
`endif
  endtask
  task automatic run8(input string tag, input logic [7:0] av, input int er, input int erem, input int ernd);
    i8.a = av;
    i8.start = 1'b1;
    @(negedge clk);
    i8.start = 1'b0;
    repeat (4) @(negedge clk);
    chk({tag, "_done"}, i8.done, 1);
    chk({tag, "_res"}, i8.result, er);
    chk({tag, "_rem"}, i8.rem, erem);
`ifdef SQRT_ROUND_EN
    chk({tag, "_rnd"}, i8.result_rnd, ernd);
`endif
  endtask
  task automatic run32(input string tag, input logic [31:0] av, input int er, input int erem, input int ernd);
    i32.a = av;
    i32.start = 1'b1;
    @(negedge clk);
    i32.start = 1'b0;
    repeat (16) @(negedge clk);
    chk({tag, "_done"}, i32.done, 1);
    chk({tag, "_res"}, i32.result, er);
    chk({tag, "_rem"}, i32.rem, erem);
`ifdef SQRT_ROUND_EN
    chk({tag, "_rnd"}, i32.result_rnd, ernd);
`endif
  endtask
  initial begin
    int n, b, seen;
    i16.start = 1'b0;
    i16.a = '0;
    i8.start = 1'b0;
    i8.a = '0;
    i32.start = 1'b0;
    i32.a = '0;
    @(negedge clk);
    chk("rst_busy", i16.busy, 0);
    chk("rst_done", i16.done, 0);
    chk("rst_res", i16.result, 0);
    chk("rst_rem", i16.rem, 0);
    reset = 1'b1;
    @(negedge clk);
    i16.a = 16'd1000;
    i16.start = 1'b1;
    @(negedge clk);
    i16.start = 1'b0;
    wait_done(n, b);
    chk("t1_lat", n, 8);
    chk("t1_busy_cycles", b, 8);
    chk("t1_busy_at_done", i16.busy, 0);
    chk("t1_res", i16.result, 31);
    chk("t1_rem", i16.rem, 39);
`ifdef SQRT_ROUND_EN
    chk("t1_rnd", i16.result_rnd, 32);
`endif
    @(negedge clk);
    chk("t1_done_pulse", i16.done, 0);
    run16("t2_zero", 16'd0, 0, 0, 0);
    run16("t2_one", 16'd1, 1, 0, 1);
    run16("t2_max", 16'hFFFF, 255, 510, 256);
    i16.a = 16'd1609;
    i16.start = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    i16.a = 16'd4;
    wait_done(n, b);
    chk("t3_done", i16.done, 1);
    chk("t3_res", i16.result, 40);
    chk("t3_rem", i16.rem, 9);
    @(negedge clk);
    chk("t3_restart_busy", i16.busy, 1);
    chk("t3_res_held", i16.result, 40);
    wait_done(n, b);
    i16.start = 1'b0;
    chk("t3b_lat", n, 8);
    chk("t3b_res", i16.result, 2);
    chk("t3b_rem", i16.rem, 0);
    i16.a = 16'd121;
    i16.start = 1'b1;
    @(negedge clk);
    i16.start = 1'b0;
    wait_done(n, b);
    chk("t4a_done", i16.done, 1);
    chk("t4a_res", i16.result, 11);
    chk("t4a_rem", i16.rem, 0);
    i16.a = 16'd100;
    i16.start = 1'b1;
    @(negedge clk);
    i16.start = 1'b0;
    wait_done(n, b);
    chk("t4_gap", n + 1, 9);
    chk("t4b_res", i16.result, 10);
    chk("t4b_rem", i16.rem, 0);
    i16.a = 16'd50000;
    i16.start = 1'b1;
    @(negedge clk);
    i16.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t5_busy", i16.busy, 0);
    chk("t5_done", i16.done, 0);
    chk("t5_res", i16.result, 0);
    chk("t5_rem", i16.rem, 0);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      seen += int'(i16.done);
    end
    chk("t5_no_done", seen, 0);
    run16("t5_ten", 16'd10, 3, 1, 3);
    run16("t6_110", 16'd110, 10, 10, 10);
    run16("t6_111", 16'd111, 10, 11, 11);
    run8("w8_110", 8'd110, 10, 10, 10);
    run8("w8_111", 8'd111, 10, 11, 11);
    run8("w8_max", 8'hFF, 15, 30, 16);
    run32("w32_110", 32'd110, 10, 10, 10);
    run32("w32_111", 32'd111, 10, 11, 11);
    run32("w32_max", 32'hFFFF_FFFF, 65535, 131070, 65536);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule

// File: doc/sqrt_iter_param.md
Name: sqrt_iter_param

Overview:
Parametrised multi-cycle unsigned integer square root. It computes floor(sqrt(a)) and the remainder a − result², using a restoring digit-by-digit algorithm that resolves one result bit per clock. This gives fixed latency independent of the operand value. It is the generalised successor to the team's 16-bit subtract-odd-numbers sqrt unit and sits beside the ALU as a start/done coprocessor.

Parameters:
WIDTH, 16, operand width in bits; must be even and >= 4 (elaboration error otherwise)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request; sampled on rising edge while ready
a  input  WIDTH  unsigned operand; sampled on the edge that accepts start
busy  output  1  high while an operation is in progress (CALC state)
done  output  1  one-cycle pulse; result/rem valid from this cycle on
result  output  WIDTH/2  floor(sqrt(a))
rem  output  WIDTH/2+1  a − result² (max 2·result, always fits)

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - busy=0, done=0, result=0, rem=0.
  - All internal registers (operand shift reg, partial root, partial remainder, iteration counter) are cleared.
  - Reset mid-CALC aborts the operation; no done pulse is produced.
- States: IDLE, CALC, DONE. Let N = WIDTH/2.
- IDLE:
  - start=1 → latch a into the operand shift register, clear the partial root and partial remainder, set counter=N−1, go to CALC.
  - start=0 → stay in IDLE.
- CALC, one iteration per edge, processing operand bit pairs MSB-first:
  - rs = (prem<<2) | top 2 operand bits; shift the operand left by 2.
  - trial = (proot<<2) | 1.
  - rs >= trial → prem = rs − trial, proot = (proot<<1)|1.
  - otherwise → prem = rs, proot = proot<<1.
  - Internal remainder datapath is N+2 bits; comparison is unsigned.
  - counter==0 on this edge → write the final proot to result and prem to rem, go to DONE.
  - otherwise → decrement counter.
- DONE: done=1 for exactly this one cycle.
  - start=1 → accepted exactly as in IDLE (back-to-back issue), go to CALC.
  - start=0 → go to IDLE.
- busy=1 exactly while in CALC.
- Latency: if start is accepted on edge E, done is high in the cycle after edge E+N. For WIDTH=16, that is 8 clocks; throughput is one result per N+1 clocks.
- start is ignored while in CALC; a is ignored except on the accepting edge.
- result and rem hold their values until the next completion. They are not cleared on start.
- a=0 and a=2^WIDTH−1 need no special-casing; the algorithm is exact over the full range.

Optional Feature:
Macro SQRT_ROUND_EN.
- Defined:
  - Adds output port result_rnd, width N+1, equal to round-to-nearest sqrt(a) = result + (rem > result ? 1 : 0).
  - Registered on the same edge as result and valid with done.
  - Reset value 0; held like result.
  - N+1 bits so that a=2^WIDTH−1 yields 2^N without overflow.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. WIDTH=16, reset released, a=1000, start pulsed 1 cycle → busy high 8 cycles, then done pulses 1 cycle, result=31, rem=39.
2. a=0, then a=1, then a=65535 → (0,0), (1,0), (255,510). With SQRT_ROUND_EN: result_rnd = 0, 1, 256.
3. a=1609 with start held high continuously; mid-CALC, change a to 4 → no restart and the change is ignored; result=40, rem=9. start still high in the DONE cycle → a new operation begins immediately with a=4; 8 clocks later result=2, rem=0.
4. Back-to-back: a=121 accepted; drive start=1 with a=100 in its DONE cycle → done pulses twice, 9 clocks apart; results (11,0) then (10,0).
5. Start a=50000; assert reset after 3 CALC cycles → busy, done, result and rem go to 0 immediately; no done pulse follows. After release, a=10 → result=3, rem=1.
6. SQRT_ROUND_EN, a=110 → result=10, rem=10, result_rnd=10. a=111 → result=10, rem=11, result_rnd=11. Repeat both with WIDTH=8 and WIDTH=32 (a=2^32−1 → result=65535, rem=131070).
